instr_fetch: RTL and testbench
==============================

# instr_fetch

Multi-cycle instruction fetch stage that owns the program counter, fetches one 32-bit instruction at a time from instruction memory over a request/acknowledge handshake, and presents it to the single-cycle control block and the datapath. It sits directly upstream of the control unit. It consumes that block's PC-source selection (00 = PC+4, 01 = branch, 10 = JAL, 11 = JALR), together with the datapath's branch outcome and targets, when the current instruction retires.

## Interface
- RESET_PC, 32'h0040_0000: PC loaded on reset.
- TIMEOUT, 255: maximum cycles in FETCH without acknowledge before a fault; 0 disables the timeout.

Ports:
- iCLK  in  1  clock; all state updates on the rising edge.
- iRST  in  1  reset, synchronous, active-high.
- oPC  out  32  address of the instruction currently held.
- oInstr  out  32  held instruction; reads NOP (32'h0000_0013) whenever oInstrValid=0.
- oInstrValid  out  1  oInstr/oPC valid for decode/execute.
- iRetire  in  1  current instruction completes this cycle; next-PC inputs are sampled on this cycle.
- iOrigPC  in  2  PC source from the control unit.
- iBranchTaken  in  1  branch comparison result, used only when iOrigPC=01.
- iBranchTarget  in  32  PC+imm for a branch or JAL.
- iJalrTarget  in  32  rs1+imm for JALR.
- oIMemAddr  out  32  fetch address, equal to oPC.
- oIMemReq  out  1  fetch request.
- iIMemAck  in  1  iIMemData valid this cycle.
- iIMemData  in  32  fetched word.
- oFault  out  1  sticky fault; the core halts.
- oFaultCause  out  2  00 none, 01 misaligned target, 10 fetch timeout.

## Operation
- States: FETCH, VALID, FAULT. After reset the state is FETCH.
- FETCH:
  - oIMemReq=1 and oIMemAddr=PC.
  - On iIMemAck: instruction register <= iIMemData, timeout counter cleared, next state VALID.
  - Otherwise the counter increments. When it reaches TIMEOUT (TIMEOUT≠0): next state FAULT, cause 10.
- VALID:
  - oInstrValid=1 and oIMemReq=0.
  - The block waits for iRetire. On iRetire it computes the next PC:
    - 00 → PC+4.
    - 01 → iBranchTarget if iBranchTaken, else PC+4.
    - 10 → iBranchTarget.
    - 11 → iJalrTarget with bit 0 cleared.
  - Misaligned next PC (bit 1 = 1 after bit-0 masking): next state FAULT, cause 01, PC unchanged.
  - Otherwise PC <= next PC and next state FETCH.
- FAULT:
  - Absorbing until iRST. Outputs are oFault=1, oIMemReq=0 and oInstrValid=0.
  - oPC holds the address of the faulting fetch or the retiring instruction.
- iIMemAck outside FETCH is ignored.
- iRetire outside VALID is ignored.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0), with no fault.

## Timing
- Reset values:
  - oPC=RESET_PC.
  - oInstr=32'h0000_0013.
  - oInstrValid=0, oIMemReq=0, oFault=0, oFaultCause=00.
  - Timeout counter=0.
- oIMemReq, oIMemAddr, oInstrValid and oFault are decoded from registered state only, with no combinational path from inputs.
  - While iRST=1, oIMemReq is forced to 0.
  - oIMemReq=1 in the first cycle after iRST deasserts.
- Handshake:
  - oIMemReq stays high, with a stable address, until the ack cycle.
  - oIMemReq is low the cycle after the ack.
  - The memory may acknowledge in the same cycle as the request.
- Latency: ack in cycle N → oInstrValid=1 in cycle N+1. Retire in cycle M → oIMemReq=1 with the new address in cycle M+1. Best case is 2 cycles per instruction.
- Timeout: with no ack, FAULT is entered TIMEOUT cycles after FETCH entry.
- Simultaneous events:
  - An ack and the timeout in the same cycle resolve in favour of the ack.
  - iRST overrides everything in every state, including mid-fetch with an outstanding request; a late ack after reset belongs to the new fetch of RESET_PC.
- Counter width is $clog2(TIMEOUT+1), minimum 1 bit.

## Structure
- Shared parameter file (Parametros.v), existing include:
  - PC-source encodings ORIGPC_PLUS4/BRANCH/JAL/JALR, the same encodings the control unit drives.
  - INSTR_NOP.
  - FAULT_NONE/MISALIGN/TIMEOUT.
  - State encodings.
- Sub-module instr_nextpc: combinational next-PC mux plus misalignment flag, instantiated once.

## Test plan
- Reset release, memory acks in the same cycle with 32'h0000_0513 → oIMemReq=1 in cycle 1, oIMemAddr=32'h0040_0000; oInstrValid=1 in cycle 2 with oInstr=32'h0000_0513.
- iRetire with iOrigPC=01:
  - iBranchTaken=0 → next address 32'h0040_0004.
  - iBranchTaken=1 with target 32'h0040_0100 → 32'h0040_0100.
- iOrigPC=11, iJalrTarget=32'h0040_0203 → fetch address 32'h0040_0202 → FAULT, cause 01, oPC unchanged.
- Memory never acks, TIMEOUT=8 → oFault=1, cause 10, exactly 8 cycles after FETCH entry; oIMemReq=0 afterwards.
- iRST asserted mid-wait, then a stray ack → no oInstrValid until a fresh request at RESET_PC is acknowledged.
- Random ack delays of 0–5 cycles over 200 instructions → oIMemAddr stable while requesting; oInstr=NOP whenever not valid; iRetire outside VALID has no effect.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared encodings for the instruction fetch stage: PC-source selects, NOP word,
// fault causes and fetch FSM states.
package instr_fetch_pkg;

   localparam logic [1:0] ORIGPC_PLUS4  = 2'b00;
   localparam logic [1:0] ORIGPC_BRANCH = 2'b01;
   localparam logic [1:0] ORIGPC_JAL    = 2'b10;
   localparam logic [1:0] ORIGPC_JALR   = 2'b11;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_VALID = 2'd1,
      S_FAULT = 2'd2
   } fetchState_t;

endpackage

// File: rtl/instr_fetch_nextpc.sv
// Combinational next-PC selection for a retiring instruction, with a flag for
// targets that are not word aligned after the JALR bit-0 clear.
import instr_fetch_pkg::*;

module instr_nextpc (
   input  logic [31:0] pc,
   input  logic [1:0]  origPc,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   input  logic [31:0] jalrTarget,
   output logic [31:0] nextPc,
   output logic        misaligned
);

   logic [31:0] pcPlus4;

   assign pcPlus4 = pc + 32'd4;

   always_comb begin
      nextPc = pcPlus4;
      case (origPc)
         ORIGPC_PLUS4:  nextPc = pcPlus4;
         ORIGPC_BRANCH: nextPc = branchTaken ? branchTarget : pcPlus4;
         ORIGPC_JAL:    nextPc = branchTarget;
         ORIGPC_JALR:   nextPc = {jalrTarget[31:1], 1'b0};
         default:       nextPc = pcPlus4;
      endcase
   end

   assign misaligned = nextPc[1];

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch: owns the PC, fetches one word per instruction over
// a req/ack handshake, holds it until retire, and halts stickily on faults.
import instr_fetch_pkg::*;

module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int          TIMEOUT  = 255
) (
   input  logic        iCLK,
   input  logic        iRST,
   output logic [31:0] oPC,
   output logic [31:0] oInstr,
   output logic        oInstrValid,
   input  logic        iRetire,
   input  logic [1:0]  iOrigPC,
   input  logic        iBranchTaken,
   input  logic [31:0] iBranchTarget,
   input  logic [31:0] iJalrTarget,
   output logic [31:0] oIMemAddr,
   output logic        oIMemReq,
   input  logic        iIMemAck,
   input  logic [31:0] iIMemData,
   output logic        oFault,
   output logic [1:0]  oFaultCause
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   fetchState_t      state, stateNext;
   logic [31:0]      pc;
   logic [31:0]      instrReg;
   logic [CNT_W-1:0] waitCnt;
   logic [1:0]       faultCause;
   logic [31:0]      nextPc;
   logic             misaligned;
   logic             timeoutHit;

   instr_nextpc uNextPc (
      .pc           (pc),
      .origPc       (iOrigPC),
      .branchTaken  (iBranchTaken),
      .branchTarget (iBranchTarget),
      .jalrTarget   (iJalrTarget),
      .nextPc       (nextPc),
      .misaligned   (misaligned)
   );

   // Last permitted wait cycle; an ack in that same cycle still wins.
   assign timeoutHit = (TIMEOUT != 0) && (waitCnt == CNT_LAST);

   always_comb begin
      stateNext = state;
      case (state)
         S_FETCH: begin
            if (iIMemAck)
               stateNext = S_VALID;
            else if (timeoutHit)
               stateNext = S_FAULT;
         end
         S_VALID: begin
            if (iRetire)
               stateNext = misaligned ? S_FAULT : S_FETCH;
         end
         S_FAULT: stateNext = S_FAULT;
         default: stateNext = S_FAULT;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         waitCnt    <= '0;
         faultCause <= FAULT_NONE;
      end else begin
         state <= stateNext;
         case (state)
            S_FETCH: begin
               if (iIMemAck)
                  waitCnt <= '0;
               else if (timeoutHit)
                  faultCause <= FAULT_TIMEOUT;
               else
                  waitCnt <= waitCnt + CNT_W'(1);
            end
            S_VALID: begin
               if (iRetire) begin
                  if (misaligned)
                     faultCause <= FAULT_MISALIGN;
                  else
                     pc <= nextPc;
               end
            end
            default: ;
         endcase
      end
   end

   // Instruction word is masked to NOP on the output, so it needs no reset.
   always_ff @(posedge iCLK) begin
      if (state == S_FETCH && iIMemAck)
         instrReg <= iIMemData;
   end

   assign oPC         = pc;
   assign oIMemAddr   = pc;
   assign oIMemReq    = (state == S_FETCH) && !iRST;
   assign oInstrValid = (state == S_VALID);
   assign oInstr      = (state == S_VALID) ? instrReg : INSTR_NOP;
   assign oFault      = (state == S_FAULT);
   assign oFaultCause = faultCause;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written multi-cycle corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam int          TMO    = 8;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        iRST, iRetire, iBranchTaken, iIMemAck;
   logic [1:0]  iOrigPC;
   logic [31:0] iBranchTarget, iJalrTarget, iIMemData;
   logic [31:0] oPC, oInstr, oIMemAddr;
   logic        oInstrValid, oIMemReq, oFault;
   logic [1:0]  oFaultCause;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
      .iCLK(clk), .iRST(iRST), .oPC(oPC), .oInstr(oInstr), .oInstrValid(oInstrValid),
      .iRetire(iRetire), .iOrigPC(iOrigPC), .iBranchTaken(iBranchTaken),
      .iBranchTarget(iBranchTarget), .iJalrTarget(iJalrTarget), .oIMemAddr(oIMemAddr),
      .oIMemReq(oIMemReq), .iIMemAck(iIMemAck), .iIMemData(iIMemData),
      .oFault(oFault), .oFaultCause(oFaultCause)
   );

   typedef struct {
      logic        rst;
      logic        ack;
      logic [31:0] data;
      logic        retire;
      logic [1:0]  orig;
      logic        taken;
      logic [31:0] bt;
      logic [31:0] jt;
   } in_t;

   typedef struct {
      logic        req;
      logic        valid;
      logic [31:0] addr;
      logic [31:0] instr;
      logic        fault;
      logic [1:0]  cause;
   } exp_t;

   typedef struct {
      in_t  in;
      exp_t exp;
   } vec_t;

   int errors = 0;
   int checks = 0;

   // Reference model: phase 0 = waiting for memory, 1 = holding an instruction, 2 = halted
   int          mPhase = 0;
   int          mWait  = 0;
   logic [31:0] mPc    = RST_PC;
   logic [31:0] mInstr = NOP;
   logic [1:0]  mCause = 2'b00;

   function automatic in_t mkIn(input logic rst, ack, input logic [31:0] data,
                                input logic retire, input logic [1:0] orig, input logic taken,
                                input logic [31:0] bt, jt);
      in_t x;
      x.rst = rst; x.ack = ack; x.data = data; x.retire = retire;
      x.orig = orig; x.taken = taken; x.bt = bt; x.jt = jt;
      return x;
   endfunction

   function automatic exp_t mkExp(input logic req, valid, input logic [31:0] addr, instr,
                                  input logic fault, input logic [1:0] cause);
      exp_t e;
      e.req = req; e.valid = valid; e.addr = addr; e.instr = instr; e.fault = fault; e.cause = cause;
      return e;
   endfunction

   function automatic in_t idle();
      return mkIn(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkOut(input string tag, input exp_t e);
      chk({tag, ".req"},   32'(oIMemReq),    32'(e.req));
      chk({tag, ".valid"}, 32'(oInstrValid), 32'(e.valid));
      chk({tag, ".pc"},    oPC,              e.addr);
      chk({tag, ".addr"},  oIMemAddr,        e.addr);
      chk({tag, ".instr"}, oInstr,           e.instr);
      chk({tag, ".fault"}, 32'(oFault),      32'(e.fault));
      chk({tag, ".cause"}, 32'(oFaultCause), 32'(e.cause));
   endtask

   function automatic exp_t modelExp(input logic rst);
      exp_t e;
      e.req   = (mPhase == 0) && !rst;
      e.valid = (mPhase == 1);
      e.addr  = mPc;
      e.instr = (mPhase == 1) ? mInstr : NOP;
      e.fault = (mPhase == 2);
      e.cause = mCause;
      return e;
   endfunction

   task automatic modelStep(input in_t x);
      logic [31:0] np;
      if (x.rst) begin
         mPhase = 0; mPc = RST_PC; mWait = 0; mCause = 2'b00;
      end else if (mPhase == 0) begin
         if (x.ack) begin
            mInstr = x.data; mWait = 0; mPhase = 1;
         end else begin
            mWait++;
            if (mWait == TMO) begin mPhase = 2; mCause = 2'b10; end
         end
      end else if (mPhase == 1 && x.retire) begin
         case (x.orig)
            2'b00:   np = mPc + 32'd4;
            2'b01:   np = x.taken ? x.bt : mPc + 32'd4;
            2'b10:   np = x.bt;
            default: np = x.jt & 32'hFFFF_FFFE;
         endcase
         if ((np & 32'h2) != 0) begin mPhase = 2; mCause = 2'b01; end
         else begin mPc = np; mPhase = 0; end
      end
   endtask

   task automatic drive(input in_t x);
      iRST = x.rst; iIMemAck = x.ack; iIMemData = x.data; iRetire = x.retire;
      iOrigPC = x.orig; iBranchTaken = x.taken; iBranchTarget = x.bt; iJalrTarget = x.jt;
      #1;
   endtask

   task automatic tick(input in_t x);
      @(posedge clk);
      modelStep(x);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[20];
      in_t  x;
      in_t  rstIn;
      int   retired;
      int   cyc;
      int   delay;
      logic [31:0] r;

      rstIn = mkIn(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

      vecs[0]  = '{mkIn(1, 0, 32'h0,        0, 2'b00, 0, 32'h0,         32'h0),
                   mkExp(0, 0, RST_PC,        NOP,           0, 2'b00)};
      vecs[1]  = '{mkIn(0, 1, 32'h0000_0513, 0, 2'b00, 0, 32'h0,        32'h0),
                   mkExp(1, 0, RST_PC,        NOP,           0, 2'b00)};
      vecs[2]  = '{mkIn(0, 0, 32'h0,        1, 2'b01, 0, 32'h0040_0100, 32'h0),
                   mkExp(0, 1, RST_PC,        32'h0000_0513, 0, 2'b00)};
      vecs[3]  = '{mkIn(0, 1, 32'h0010_0093, 0, 2'b00, 0, 32'h0,        32'h0),
                   mkExp(1, 0, 32'h0040_0004, NOP,           0, 2'b00)};
      vecs[4]  = '{mkIn(0, 0, 32'h0,        1, 2'b01, 1, 32'h0040_0100, 32'h0),
                   mkExp(0, 1, 32'h0040_0004, 32'h0010_0093, 0, 2'b00)};
      vecs[5]  = '{mkIn(0, 0, 32'h0,        0, 2'b00, 0, 32'h0,         32'h0),
                   mkExp(1, 0, 32'h0040_0100, NOP,           0, 2'b00)};
      vecs[6]  = '{mkIn(0, 1, 32'h0020_0113, 0, 2'b00, 0, 32'h0,        32'h0),
                   mkExp(1, 0, 32'h0040_0100, NOP,           0, 2'b00)};
      vecs[7]  = '{mkIn(0, 0, 32'h0,        1, 2'b11, 0, 32'h0,         32'h0040_0203),
                   mkExp(0, 1, 32'h0040_0100, 32'h0020_0113, 0, 2'b00)};
      vecs[8]  = '{mkIn(0, 0, 32'h0,        0, 2'b00, 0, 32'h0,         32'h0),
                   mkExp(0, 0, 32'h0040_0100, NOP,           1, 2'b01)};
      vecs[9]  = '{mkIn(0, 1, 32'hDEAD_BEEF, 1, 2'b00, 0, 32'h0,        32'h0),
                   mkExp(0, 0, 32'h0040_0100, NOP,           1, 2'b01)};
      vecs[10] = '{mkIn(1, 0, 32'h0,        0, 2'b00, 0, 32'h0,         32'h0),
                   mkExp(0, 0, 32'h0040_0100, NOP,           1, 2'b01)};
      vecs[11] = '{mkIn(0, 1, 32'h0080_006F, 0, 2'b00, 0, 32'h0,        32'h0),
                   mkExp(1, 0, RST_PC,        NOP,           0, 2'b00)};
      vecs[12] = '{mkIn(0, 0, 32'h0,        1, 2'b10, 0, 32'h0040_0020, 32'h0),
                   mkExp(0, 1, RST_PC,        32'h0080_006F, 0, 2'b00)};
      vecs[13] = '{mkIn(0, 1, 32'h00A0_0093, 0, 2'b00, 0, 32'h0,        32'h0),
                   mkExp(1, 0, 32'h0040_0020, NOP,           0, 2'b00)};
      vecs[14] = '{mkIn(0, 0, 32'h0,        1, 2'b00, 0, 32'h0,         32'h0),
                   mkExp(0, 1, 32'h0040_0020, 32'h00A0_0093, 0, 2'b00)};
      vecs[15] = '{mkIn(0, 1, 32'h0000_0013, 0, 2'b00, 0, 32'h0,        32'h0),
                   mkExp(1, 0, 32'h0040_0024, NOP,           0, 2'b00)};
      vecs[16] = '{mkIn(0, 0, 32'h0,        1, 2'b10, 0, 32'hFFFF_FFFC, 32'h0),
                   mkExp(0, 1, 32'h0040_0024, 32'h0000_0013, 0, 2'b00)};
      vecs[17] = '{mkIn(0, 1, 32'h0000_0033, 0, 2'b00, 0, 32'h0,        32'h0),
                   mkExp(1, 0, 32'hFFFF_FFFC, NOP,           0, 2'b00)};
      vecs[18] = '{mkIn(0, 0, 32'h0,        1, 2'b00, 0, 32'h0,         32'h0),
                   mkExp(0, 1, 32'hFFFF_FFFC, 32'h0000_0033, 0, 2'b00)};
      vecs[19] = '{mkIn(0, 0, 32'h0,        0, 2'b00, 0, 32'h0,         32'h0),
                   mkExp(1, 0, 32'h0000_0000, NOP,           0, 2'b00)};

      drive(rstIn);
      @(negedge clk);
      tick(rstIn);
      tick(rstIn);

      foreach (vecs[i]) begin
         drive(vecs[i].in);
         chkOut($sformatf("vec%0d", i), vecs[i].exp);
         tick(vecs[i].in);
      end

      // Timeout: no ack, fault exactly TMO cycles after entering fetch
      drive(rstIn); tick(rstIn);
      for (int k = 0; k < TMO; k++) begin
         drive(idle());
         chk($sformatf("tmo.req%0d", k), 32'(oIMemReq), 32'd1);
         chk($sformatf("tmo.nofault%0d", k), 32'(oFault), 32'd0);
         tick(idle());
      end
      drive(idle());
      chkOut("tmo.hit", mkExp(0, 0, RST_PC, NOP, 1, 2'b10));
      tick(idle());
      drive(idle());
      chkOut("tmo.held", mkExp(0, 0, RST_PC, NOP, 1, 2'b10));
      tick(idle());

      // Ack on the last permitted cycle beats the timeout
      drive(rstIn); tick(rstIn);
      for (int k = 0; k < TMO - 1; k++) begin
         drive(idle()); tick(idle());
      end
      x = idle(); x.ack = 1'b1; x.data = 32'h1234_5678;
      drive(x);
      chk("race.req", 32'(oIMemReq), 32'd1);
      tick(x);
      drive(idle());
      chkOut("race.win", mkExp(0, 1, RST_PC, 32'h1234_5678, 0, 2'b00));

      // Reset mid-wait with a stray ack during reset
      x = idle(); x.retire = 1'b1;
      drive(x); tick(x);
      for (int k = 0; k < 2; k++) begin
         drive(idle());
         chk($sformatf("mid.addr%0d", k), oIMemAddr, 32'h0040_0004);
         tick(idle());
      end
      x = rstIn; x.ack = 1'b1; x.data = 32'hDEAD_BEEF;
      drive(x);
      chk("mid.reqInRst", 32'(oIMemReq), 32'd0);
      tick(x);
      drive(idle());
      chkOut("mid.refetch", mkExp(1, 0, RST_PC, NOP, 0, 2'b00));
      tick(idle());
      x = idle(); x.ack = 1'b1; x.data = 32'h0000_0513;
      drive(x);
      chk("mid.stillNotValid", 32'(oInstrValid), 32'd0);
      tick(x);
      drive(idle());
      chkOut("mid.fresh", mkExp(0, 1, RST_PC, 32'h0000_0513, 0, 2'b00));

      // Randomized traffic against the reference model
      drive(rstIn); tick(rstIn);
      retired = 0;
      cyc = 0;
      delay = $urandom_range(5);
      while (retired < 200 && cyc < 20000) begin
         x.rst    = (mPhase == 2);
         x.ack    = (mPhase == 0) ? (mWait == delay) : ($urandom_range(3) == 0);
         x.data   = $urandom;
         x.retire = ($urandom_range(1) == 1);
         x.orig   = 2'($urandom_range(3));
         x.taken  = ($urandom_range(1) == 1);
         r        = $urandom;
         x.bt     = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : (r & 32'hFFFF_FFFC);
         r        = $urandom;
         x.jt     = ($urandom_range(9) == 0) ? r : (r & 32'hFFFF_FFFD);
         if (mPhase == 0 && x.ack && !x.rst) delay = $urandom_range(5);
         if (mPhase == 1 && x.retire && !x.rst) retired++;
         drive(x);
         chkOut("rnd", modelExp(x.rst));
         tick(x);
         cyc++;
      end
      chk("rnd.retired", 32'(retired), 32'd200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
